// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types, constants and helpers for the FFT stage control blocks
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GAP   = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

    localparam int FFT_LANES = 16;
    localparam int FFT_BEATS = 32;

    // Width of a beat index within a frame; never narrower than one bit.
    function automatic int beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fft_out_tagger.sv
// rtl/fft_out_tagger.sv - sof/eof/frame-id tagging of a stage's output beat stream
module fft_out_tagger
    import fft_ctrl_pkg::*;
#(
    parameter int BEATS = FFT_BEATS,
    parameter int ID_W  = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    input  logic            valid,
    output logic            sof,
    output logic            eof,
    output logic [ID_W-1:0] id
);

    localparam int            BW        = beat_w(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [BW-1:0] out_beat;

    assign sof = valid && (out_beat == '0);
    assign eof = valid && (out_beat == LAST_BEAT);

    // Output beat position and frame id; BEATS is a power of two so the beat count wraps by itself.
    always_ff @(posedge clk) begin
        if (rstn || clr) begin
            out_beat <= '0;
            id       <= '0;
        end else if (valid) begin
            out_beat <= out_beat + BW'(1);
            if (eof) begin
                id <= id + ID_W'(1);
            end
        end
    end

endmodule

// File: rtl/fft_stage_sched.sv
// rtl/fft_stage_sched.sv - frame scheduler: input gating, credits, flush and output tagging for an FFT stage
module fft_stage_sched
    import fft_ctrl_pkg::*;
#(
    parameter int BEATS   = FFT_BEATS,
    parameter int CREDITS = 4,
    parameter int GAP_CYC = 0,
    parameter int ID_W    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            src_valid,
    input  logic            src_last,
    output logic            src_ready,
    output logic            stg_valid_in,
    input  logic            stg_valid_out,
    input  logic            credit_ret,
    input  logic            flush_req,
    output logic            flush_done,
    output logic            out_sof,
    output logic            out_eof,
    output logic [ID_W-1:0] out_id,
    output logic            err_len,
    output logic            err_cred,
    output logic            err_unf,
    output logic            busy
);

    localparam int            BW        = beat_w(BEATS);
    localparam int            CW        = $clog2(CREDITS + 1);
    localparam int            IW        = $clog2(BEATS * CREDITS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [3:0]    GAP_LOAD  = 4'(GAP_CYC - 1);

    sched_state_t  state;
    logic [BW-1:0] in_beat;
    logic [CW-1:0] credits;
    logic [IW-1:0] inflight;
    logic [3:0]    gap_cnt;
    logic          flush_pend;

    logic beat_last;
    logic frame_start;
    logic frame_end;
    logic flush_go;

    assign beat_last    = (in_beat == LAST_BEAT);
    assign stg_valid_in = src_valid && src_ready;
    assign frame_start  = stg_valid_in && (state == IDLE);
    assign frame_end    = stg_valid_in && (state == RUN) && beat_last;
    assign flush_go     = (state == FLUSH) && (inflight == '0);
    assign busy         = (state != IDLE) || (inflight != '0);

    // Input acceptance depends only on state, credits and flush intent; RUN never stalls a frame.
    always_comb begin
        src_ready = 1'b0;
        case (state)
            IDLE:    src_ready = (credits != '0) && !flush_pend && !flush_req;
            RUN:     src_ready = 1'b1;
            default: src_ready = 1'b0;
        endcase
    end

    // Frame FSM: beat counting, length check, gap timing and flush sequencing.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= IDLE;
            in_beat    <= '0;
            gap_cnt    <= '0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (stg_valid_in) begin
                in_beat <= beat_last ? '0 : in_beat + BW'(1);
                if (src_last != beat_last) begin
                    err_len <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH;
                    end else if (frame_start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (frame_end) begin
                        flush_pend <= 1'b0;
                        if (flush_pend || flush_req) begin
                            state <= FLUSH;
                        end else if (GAP_CYC > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush_req) begin
                        flush_pend <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        flush_pend <= 1'b0;
                        state      <= (flush_pend || flush_req) ? FLUSH : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                        if (flush_req) begin
                            flush_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (flush_go) begin
                        flush_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

    // Beats inside the stage: up on entry, down on exit, floor at zero with an underflow flag.
    always_ff @(posedge clk) begin
        if (rstn) begin
            inflight <= '0;
            err_unf  <= 1'b0;
        end else begin
            case ({stg_valid_in, stg_valid_out})
                2'b10: inflight <= inflight + IW'(1);
                2'b01: begin
                    if (inflight == '0) begin
                        err_unf <= 1'b1;
                    end else begin
                        inflight <= inflight - IW'(1);
                    end
                end
                default: inflight <= inflight;
            endcase
        end
    end

    // Downstream frame credits: spent at frame start, returned by the buffer, saturating at the reset value.
    always_ff @(posedge clk) begin
        if (rstn) begin
            credits  <= CRED_MAX;
            err_cred <= 1'b0;
        end else if (frame_start && !credit_ret) begin
            credits <= credits - CW'(1);
        end else if (credit_ret && !frame_start) begin
            if (credits == CRED_MAX) begin
                err_cred <= 1'b1;
            end else begin
                credits <= credits + CW'(1);
            end
        end
    end

    fft_out_tagger #(
        .BEATS (BEATS),
        .ID_W  (ID_W)
    ) u_tagger (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (flush_go),
        .valid (stg_valid_out),
        .sof   (out_sof),
        .eof   (out_eof),
        .id    (out_id)
    );

endmodule

// File: tb/tb_fft_stage_sched.sv
// tb/tb_fft_stage_sched.sv - directed self-checking bench for fft_stage_sched
module tb_fft_stage_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, src_valid, src_last, stg_valid_out, credit_ret, flush_req;
    logic       src_ready, stg_valid_in, flush_done, out_sof, out_eof;
    logic [3:0] out_id;
    logic       err_len, err_cred, err_unf, busy;
    logic       g_src_ready, g_stg_valid_in, g_flush_done, g_out_sof, g_out_eof;
    logic [3:0] g_out_id;
    logic       g_err_len, g_err_cred, g_err_unf, g_busy;

    int n_checks = 0;
    int n_errors = 0;
    int acc;
    int cyc;

    fft_stage_sched #(.BEATS(32), .CREDITS(4), .GAP_CYC(0), .ID_W(4)) u_dut (
        .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_last(src_last),
        .src_ready(src_ready), .stg_valid_in(stg_valid_in), .stg_valid_out(stg_valid_out),
        .credit_ret(credit_ret), .flush_req(flush_req), .flush_done(flush_done),
        .out_sof(out_sof), .out_eof(out_eof), .out_id(out_id), .err_len(err_len),
        .err_cred(err_cred), .err_unf(err_unf), .busy(busy)
    );

    fft_stage_sched #(.BEATS(32), .CREDITS(4), .GAP_CYC(3), .ID_W(4)) u_dut_gap (
        .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_last(src_last),
        .src_ready(g_src_ready), .stg_valid_in(g_stg_valid_in), .stg_valid_out(stg_valid_out),
        .credit_ret(credit_ret), .flush_req(flush_req), .flush_done(g_flush_done),
        .out_sof(g_out_sof), .out_eof(g_out_eof), .out_id(g_out_id), .err_len(g_err_len),
        .err_cred(g_err_cred), .err_unf(g_err_unf), .busy(g_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_valid     = 1'b0;
        src_last      = 1'b0;
        stg_valid_out = 1'b0;
        credit_ret    = 1'b0;
        flush_req     = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1;
        idle_inputs();

        // Reset state and single frame with outputs three cycles behind the inputs
        do_reset();
        #1;
        check("rst_ready", src_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_errs", {err_len, err_cred, err_unf}, 0);
        check("rst_out_id", out_id, 0);
        check("rst_vin0", stg_valid_in, 0);
        src_valid = 1'b1;
        #1;
        check("rst_vin1", stg_valid_in, 1);
        src_valid = 1'b0;
        for (int c = 0; c < 38; c++) begin
            src_valid     = (c < 32);
            src_last      = (c == 31);
            stg_valid_out = (c >= 3) && (c < 35);
            #1;
            check("t1_vin", stg_valid_in, (c < 32));
            if (c == 0) check("t1_credits4", u_dut.credits, 4);
            if (c == 1) check("t1_credits3", u_dut.credits, 3);
            if (c == 3) begin
                check("t1_sof_first", out_sof, 1);
                check("t1_eof_first", out_eof, 0);
                check("t1_id_first", out_id, 0);
            end
            if (c == 34) begin
                check("t1_sof_last", out_sof, 0);
                check("t1_eof_last", out_eof, 1);
                check("t1_id_last", out_id, 0);
                check("t1_busy_last", busy, 1);
            end
            if (c == 35) begin
                check("t1_id_next", out_id, 1);
                check("t1_busy_done", busy, 0);
            end
            tick();
        end
        idle_inputs();

        // Credit stall: four frames with no credit return
        do_reset();
        acc = 0;
        cyc = 0;
        while (acc < 128 && cyc < 300) begin
            src_valid = 1'b1;
            src_last  = ((acc % 32) == 31);
            #1;
            if (src_ready) acc++;
            tick();
            cyc++;
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
        #1;
        check("t2_beats", acc, 128);
        check("t2_ready_stall", src_ready, 0);
        check("t2_credits0", u_dut.credits, 0);
        tick();
        credit_ret = 1'b1;
        #1;
        check("t2_ready_same", src_ready, 0);
        tick();
        credit_ret = 1'b0;
        #1;
        check("t2_ready_rise", src_ready, 1);
        check("t2_credits1", u_dut.credits, 1);
        for (int k = 0; k < 3; k++) begin
            credit_ret = 1'b1;
            tick();
            credit_ret = 1'b0;
            tick();
        end
        check("t2_credits_full", u_dut.credits, 4);
        check("t2_cred_ok", err_cred, 0);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        #1;
        check("t2_err_cred", err_cred, 1);
        check("t2_credits_sat", u_dut.credits, 4);

        // Gap of three cycles and src_last on the wrong beat
        do_reset();
        for (int c = 0; c < 37; c++) begin
            src_valid = (c < 32);
            src_last  = (c == 30);
            #1;
            if (c == 30) check("t3_errlen_pre", g_err_len, 0);
            if (c == 31) begin
                check("t3_errlen", g_err_len, 1);
                check("t3_ready_b31", g_src_ready, 1);
            end
            if (c >= 32 && c <= 34) check("t3_gap_ready", g_src_ready, 0);
            if (c == 32) check("t3_nogap_ready", src_ready, 1);
            if (c == 35) check("t3_gap_end", g_src_ready, 1);
            tick();
        end
        idle_inputs();

        // Flush requested mid-frame
        do_reset();
        for (int c = 0; c < 43; c++) begin
            src_valid     = (c < 32) || (c >= 36);
            src_last      = (c == 31);
            flush_req     = (c == 10);
            stg_valid_out = ((c >= 3) && (c < 35)) || (c >= 39);
            #1;
            if (c == 31) check("t4_ready_b31", src_ready, 1);
            if (c == 32) begin
                check("t4_ready_flush", src_ready, 0);
                check("t4_busy", busy, 1);
            end
            if (c == 34) check("t4_fd_early", flush_done, 0);
            if (c == 35) begin
                check("t4_fd_wait", flush_done, 0);
                check("t4_ready_wait", src_ready, 0);
                check("t4_id_pre", out_id, 1);
            end
            if (c == 36) begin
                check("t4_fd_pulse", flush_done, 1);
                check("t4_id_clr", out_id, 0);
                check("t4_ready_idle", src_ready, 1);
            end
            if (c == 37) check("t4_fd_end", flush_done, 0);
            if (c == 39) begin
                check("t4_next_sof", out_sof, 1);
                check("t4_next_id", out_id, 0);
            end
            tick();
        end
        idle_inputs();

        // Underflow, then reset in the middle of a frame
        do_reset();
        stg_valid_out = 1'b1;
        #1;
        check("t5_unf_pre", err_unf, 0);
        tick();
        stg_valid_out = 1'b0;
        #1;
        check("t5_unf", err_unf, 1);
        for (int c = 0; c < 16; c++) begin
            src_valid = 1'b1;
            src_last  = 1'b0;
            if (c == 15) rstn = 1'b1;
            #1;
            if (c == 14) check("t5_busy_pre", busy, 1);
            tick();
        end
        rstn = 1'b0;
        idle_inputs();
        #1;
        check("t5_ready", src_ready, 1);
        check("t5_busy", busy, 0);
        check("t5_unf_clr", err_unf, 0);
        check("t5_len_cred", {err_len, err_cred}, 0);
        check("t5_fd", flush_done, 0);
        check("t5_sof_eof", {out_sof, out_eof}, 0);
        check("t5_out_id", out_id, 0);
        check("t5_credits", u_dut.credits, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
